coin_acceptor: RTL and testbench

- Front end of the vending datapath: converts the raw coin-slot sensor into clean coin codes for the vending FSM's 2-bit coin input.
- Code 01 = 5 rs, code 10 = 10 rs, 00 = no coin.
- Synchronises and debounces the sensor, measures pulse width, and classifies the coin or rejects it.
- Presents each accepted coin through a valid/ready handshake; flags jams and overruns.

---
 rtl/coin_pkg.sv | 25 ++
 rtl/coin_debounce.sv | 44 ++++
 rtl/coin_acceptor.sv | 150 +++++++++++++++
 tb/tb_coin_acceptor.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/coin_pkg.sv
// Shared coin codes, measurement states and coin values for the coin-slot front end.
// The COIN_TOTAL_EN build also uses coin_value() to accumulate credit.
package coin_pkg;

   localparam logic [1:0] COIN_NONE = 2'b00;
   localparam logic [1:0] COIN_5    = 2'b01;
   localparam logic [1:0] COIN_10   = 2'b10;

   typedef logic [1:0] meas_state_t;
   localparam meas_state_t ST_IDLE    = 2'd0;
   localparam meas_state_t ST_MEASURE = 2'd1;
   localparam meas_state_t ST_JAM     = 2'd2;

   localparam logic [15:0] COIN_VAL_5  = 16'd5;
   localparam logic [15:0] COIN_VAL_10 = 16'd10;

   function automatic logic [15:0] coin_value(input logic [1:0] code);
      case (code)
         COIN_5:  return COIN_VAL_5;
         COIN_10: return COIN_VAL_10;
         default: return 16'd0;
      endcase
   endfunction

endpackage

// File: rtl/coin_debounce.sv
// Synchroniser chain plus stability counter for the raw coin-slot sensor.
// The level flips only after DEBOUNCE_CYC consecutive disagreeing samples.
module coin_debounce #(
   parameter int SYNC_STAGES  = 2,
   parameter int DEBOUNCE_CYC = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic i_raw,
   output logic o_level
);

   localparam int               CNT_W  = $clog2(DEBOUNCE_CYC + 1);
   localparam logic [CNT_W-1:0] L_LAST = CNT_W'(DEBOUNCE_CYC - 1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic [CNT_W-1:0]       r_cnt;
   logic                   r_level;
   logic                   w_sync;

   assign w_sync  = r_sync[SYNC_STAGES-1];
   assign o_level = r_level;

   // NOTE: sequential state uses <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync  <= '0;
         r_cnt   <= '0;
         r_level <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
         // Counting on the last disagreeing sample keeps latency = SYNC_STAGES + DEBOUNCE_CYC.
         if (w_sync == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == L_LAST) begin
            r_level <= w_sync;
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/coin_acceptor.sv
// Coin-slot front end: debounce, width measurement, classification and a one-entry output slot.
// Optional macro COIN_TOTAL_EN adds the saturating total_rs credit counter.
module coin_acceptor
   import coin_pkg::*;
#(
   parameter int SYNC_STAGES  = 2,
   parameter int DEBOUNCE_CYC = 4,
   parameter int W5_MIN       = 20,
   parameter int W5_MAX       = 40,
   parameter int W10_MIN      = 60,
   parameter int W10_MAX      = 90,
   parameter int TIMEOUT_CYC  = 200,
   parameter int WID_W        = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        coin_sense,
   input  logic        coin_ready,
   output logic        coin_valid,
   output logic [1:0]  coin_code,
   output logic        reject,
   output logic        jam
`ifdef COIN_TOTAL_EN
   ,
   output logic [15:0] total_rs
`endif
);

   localparam logic [WID_W-1:0] L_W5_MIN  = WID_W'(W5_MIN);
   localparam logic [WID_W-1:0] L_W5_MAX  = WID_W'(W5_MAX);
   localparam logic [WID_W-1:0] L_W10_MIN = WID_W'(W10_MIN);
   localparam logic [WID_W-1:0] L_W10_MAX = WID_W'(W10_MAX);
   localparam logic [WID_W-1:0] L_TIMEOUT = WID_W'(TIMEOUT_CYC);

   logic             w_deb;
   meas_state_t      r_state,  w_state_nxt;
   logic [WID_W-1:0] r_width,  w_width_nxt;
   logic [1:0]       w_class;
   logic             w_fall_meas;
   logic             w_fall_jam;
   logic             w_slot_free;
   logic             w_handshake;
   logic             w_load;
   logic             w_reject_evt;
   logic             r_valid;
   logic [1:0]       r_code;
   logic             r_reject;

   coin_debounce #(
      .SYNC_STAGES  (SYNC_STAGES),
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
   ) u_debounce (
      .clk     (clk),
      .rst     (rst),
      .i_raw   (coin_sense),
      .o_level (w_deb)
   );

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      w_class = COIN_NONE;
      if (r_width >= L_W5_MIN && r_width <= L_W5_MAX) begin
         w_class = COIN_5;
      end else if (r_width >= L_W10_MIN && r_width <= L_W10_MAX) begin
         w_class = COIN_10;
      end
   end

   // Classification happens in the debounced-fall cycle; the slot loads on the following edge.
   assign w_fall_meas  = (r_state == ST_MEASURE) && !w_deb;
   assign w_fall_jam   = (r_state == ST_JAM) && !w_deb;
   assign w_handshake  = r_valid && coin_ready;
   assign w_slot_free  = !r_valid || coin_ready;
   assign w_load       = w_fall_meas && (w_class != COIN_NONE) && w_slot_free;
   assign w_reject_evt = w_fall_jam || (w_fall_meas && !w_load);

   always_comb begin
      w_state_nxt = r_state;
      w_width_nxt = r_width;
      case (r_state)
         ST_IDLE: begin
            if (w_deb) begin
               w_width_nxt = WID_W'(1);
               w_state_nxt = ST_MEASURE;
            end
         end
         ST_MEASURE: begin
            if (!w_deb) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_width_nxt = r_width + WID_W'(1);
               if (w_width_nxt == L_TIMEOUT) begin
                  w_state_nxt = ST_JAM;
               end
            end
         end
         ST_JAM: begin
            if (!w_deb) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // NOTE: reset is synchronous, sampled on clk like the rest of the vending datapath.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_width  <= '0;
         r_valid  <= 1'b0;
         r_code   <= COIN_NONE;
         r_reject <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_width  <= w_width_nxt;
         r_reject <= w_reject_evt;
         if (w_load) begin
            r_valid <= 1'b1;
            r_code  <= w_class;
         end else if (w_handshake) begin
            r_valid <= 1'b0;
            r_code  <= COIN_NONE;
         end
      end
   end

   assign coin_valid = r_valid;
   assign coin_code  = r_code;
   assign reject     = r_reject;
   assign jam        = (r_state == ST_JAM);

`ifdef COIN_TOTAL_EN
   logic [15:0] r_total;
   logic [16:0] w_sum;

   assign w_sum = {1'b0, r_total} + {1'b0, coin_value(r_code)};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_total <= '0;
      end else if (w_handshake) begin
         r_total <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
      end
   end

   assign total_rs = r_total;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: coin widths, bounds, glitches, jam, overrun and mid-coin reset.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_coin_acceptor;

   logic        clk = 1'b0;
   logic        rst;
   logic        coin_sense;
   logic        coin_ready;
   logic        coin_valid;
   logic [1:0]  coin_code;
   logic        reject;
   logic        jam;
`ifdef COIN_TOTAL_EN
   logic [15:0] total_rs;
`endif

   int checks = 0;
   int errors = 0;
   int exp_total = 0;

   int         n_rej;
   int         n_val;
   logic [1:0] seen_code;

   always #5 clk = ~clk;

   coin_acceptor dut (
      .clk        (clk),
      .rst        (rst),
      .coin_sense (coin_sense),
      .coin_ready (coin_ready),
      .coin_valid (coin_valid),
      .coin_code  (coin_code),
      .reject     (reject),
      .jam        (jam)
`ifdef COIN_TOTAL_EN
      ,
      .total_rs   (total_rs)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Watch n falling edges, counting reject pulses and valid cycles; coin_code must be 00 when idle.
   task automatic observe(input int n, output int o_rej, output int o_val, output logic [1:0] o_code);
      int bad;
      o_rej  = 0;
      o_val  = 0;
      o_code = 2'b00;
      bad    = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (reject === 1'b1) o_rej++;
         if (coin_valid === 1'b1) begin
            o_val++;
            o_code = coin_code;
         end else if (coin_code !== 2'b00) begin
            bad++;
         end
      end
      check("code_zero_when_idle", bad, 0);
   endtask

   task automatic pulse(input int w);
      coin_sense = 1'b1;
      repeat (w) @(negedge clk);
      coin_sense = 1'b0;
   endtask

   task automatic check_total(input string tag);
`ifdef COIN_TOTAL_EN
      check(tag, total_rs, exp_total);
`endif
   endtask

   // Accepted coin with ready held high: exactly one valid cycle of the given code.
   task automatic accepted(input string tag, input int w, input logic [1:0] code, input int value);
      pulse(w);
      observe(12, n_rej, n_val, seen_code);
      exp_total += value;
      check({tag, "_rej"}, n_rej, 0);
      check({tag, "_val"}, n_val, 1);
      check({tag, "_code"}, seen_code, code);
      check_total({tag, "_total"});
   endtask

   task automatic rejected(input string tag, input int w);
      pulse(w);
      observe(12, n_rej, n_val, seen_code);
      check({tag, "_rej"}, n_rej, 1);
      check({tag, "_val"}, n_val, 0);
   endtask

   initial begin
      rst        = 1'b1;
      coin_sense = 1'b0;
      coin_ready = 1'b0;
      repeat (4) @(negedge clk);
      check("rst_valid", coin_valid, 0);
      check("rst_code", coin_code, 2'b00);
      check("rst_reject", reject, 0);
      check("rst_jam", jam, 0);
      check_total("rst_total");
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // 30-cycle coin held while ready is low, released by a handshake
      pulse(30);
      observe(12, n_rej, n_val, seen_code);
      check("c5_rej", n_rej, 0);
      check("c5_valid", coin_valid, 1);
      check("c5_code", coin_code, 2'b01);
      repeat (20) @(negedge clk);
      check("c5_hold_valid", coin_valid, 1);
      check("c5_hold_code", coin_code, 2'b01);
      coin_ready = 1'b1;
      @(negedge clk);
      exp_total += 5;
      check("c5_after_hs_valid", coin_valid, 0);
      check("c5_after_hs_code", coin_code, 2'b00);
      check_total("c5_total");
      coin_ready = 1'b0;
      repeat (3) @(negedge clk);

      // 75-cycle coin with ready high: one-cycle valid of code 10
      coin_ready = 1'b1;
      accepted("c10", 75, 2'b10, 10);

      // Bad width and glitches
      rejected("w50", 50);
      for (int g = 0; g < 4; g++) begin
         pulse(3);
         repeat (3) @(negedge clk);
      end
      observe(12, n_rej, n_val, seen_code);
      check("glitch_rej", n_rej, 0);
      check("glitch_val", n_val, 0);
      check("glitch_jam", jam, 0);

      // Inclusive range bounds
      accepted("w20", 20, 2'b01, 5);
      accepted("w40", 40, 2'b01, 5);
      accepted("w60", 60, 2'b10, 10);
      accepted("w90", 90, 2'b10, 10);
      rejected("w19", 19);
      rejected("w91", 91);

      // Jam: width reaches 200 at the 206th edge after the raw rise
      coin_sense = 1'b1;
      repeat (205) @(negedge clk);
      check("jam_before", jam, 0);
      @(negedge clk);
      check("jam_rise", jam, 1);
      repeat (250 - 206) @(negedge clk);
      check("jam_hold", jam, 1);
      coin_sense = 1'b0;
      observe(12, n_rej, n_val, seen_code);
      check("jam_rej", n_rej, 1);
      check("jam_val", n_val, 0);
      check("jam_clear", jam, 0);
      check_total("jam_total");

      // Overrun: second coin is rejected while the first is held
      coin_ready = 1'b0;
      pulse(30);
      observe(12, n_rej, n_val, seen_code);
      check("ovr_first_rej", n_rej, 0);
      check("ovr_first_code", coin_code, 2'b01);
      pulse(30);
      observe(12, n_rej, n_val, seen_code);
      check("ovr_second_rej", n_rej, 1);
      check("ovr_second_valid_cycles", n_val, 12);
      check("ovr_held_code", coin_code, 2'b01);
      coin_ready = 1'b1;
      @(negedge clk);
      exp_total += 5;
      check("ovr_release_valid", coin_valid, 0);
      check_total("ovr_total");
      coin_ready = 1'b0;

      // Reset at width 15 with a coin held in the slot
      pulse(30);
      observe(12, n_rej, n_val, seen_code);
      check("mid_pre_valid", coin_valid, 1);
      coin_sense = 1'b1;
      repeat (21) @(negedge clk);
      rst        = 1'b1;
      coin_sense = 1'b0;
      @(negedge clk);
      exp_total = 0;
      check("mid_rst_valid", coin_valid, 0);
      check("mid_rst_code", coin_code, 2'b00);
      check("mid_rst_reject", reject, 0);
      check("mid_rst_jam", jam, 0);
      check_total("mid_rst_total");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      observe(12, n_rej, n_val, seen_code);
      check("mid_after_rej", n_rej, 0);
      check("mid_after_val", n_val, 0);
      coin_ready = 1'b1;
      accepted("mid_next", 75, 2'b10, 10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
